// File: rtl/phy_rx_deserializer.sv
// rtl/phy_rx_deserializer.sv - serial lane receiver: COM byte alignment, IDL stripping, 32-bit word reassembly
module phy_rx_deserializer #(
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter logic [7:0] IDL_SYM   = 8'h7C,
    parameter int         COM_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active,
    output logic        word_err
);

    localparam int CW = $clog2(COM_COUNT + 1);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    shift;
    logic [7:0]    window;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [1:0]    byte_cnt, byte_cnt_nxt;
    logic [CW-1:0] com_cnt, com_cnt_nxt, com_inc;
    logic [23:0]   word_buf;
    logic          active_nxt, valid_nxt, err_nxt;
    logic          buf_we, word_we;
    logic          byte_done, is_com, is_idl, com_full;

    assign window    = {shift, data_in};
    assign byte_done = (state != UNSYNC) && (bit_cnt == 3'd7);
    assign is_com    = (window == COM_SYM);
    assign is_idl    = (window == IDL_SYM);
    assign com_inc   = com_cnt + 1'b1;
    assign com_full  = (com_inc == CW'(COM_COUNT));

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt + 3'd1;
        byte_cnt_nxt = byte_cnt;
        com_cnt_nxt  = com_cnt;
        active_nxt   = active;
        valid_nxt    = 1'b0;
        err_nxt      = 1'b0;
        buf_we       = 1'b0;
        word_we      = 1'b0;
        case (state)
            UNSYNC: begin
                // Sliding search: the byte just matched ends here, so the next bit is an MSB.
                bit_cnt_nxt = 3'd0;
                if (is_com) begin
                    com_cnt_nxt = CW'(1);
                    state_nxt   = SYNC;
                end
            end
            SYNC: begin
                if (byte_done) begin
                    if (is_com && com_full) begin
                        com_cnt_nxt  = '0;
                        active_nxt   = 1'b1;
                        byte_cnt_nxt = 2'd0;
                        state_nxt    = ACTIVE;
                    end else if (is_com) begin
                        com_cnt_nxt = com_inc;
                    end else begin
                        com_cnt_nxt = '0;
                        state_nxt   = UNSYNC;
                    end
                end
            end
            ACTIVE: begin
                if (byte_done) begin
                    if (is_com || is_idl) begin
                        err_nxt      = (byte_cnt != 2'd0);
                        byte_cnt_nxt = 2'd0;
                        com_cnt_nxt  = '0;
                        if (is_com && com_full) begin
                            // Transmitter went inactive; byte alignment is still valid.
                            active_nxt = 1'b0;
                            state_nxt  = SYNC;
                        end else if (is_com) begin
                            com_cnt_nxt = com_inc;
                        end
                    end else begin
                        com_cnt_nxt = '0;
                        if (byte_cnt == 2'd3) begin
                            word_we      = 1'b1;
                            valid_nxt    = 1'b1;
                            byte_cnt_nxt = 2'd0;
                        end else begin
                            buf_we       = 1'b1;
                            byte_cnt_nxt = byte_cnt + 2'd1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = UNSYNC;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state <= UNSYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            com_cnt   <= '0;
            word_buf  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
            word_err  <= 1'b0;
        end else begin
            shift     <= window[6:0];
            bit_cnt   <= bit_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
            com_cnt   <= com_cnt_nxt;
            active    <= active_nxt;
            valid_out <= valid_nxt;
            word_err  <= err_nxt;
            if (buf_we) begin
                case (byte_cnt)
                    2'd0:    word_buf[23:16] <= window;
                    2'd1:    word_buf[15:8]  <= window;
                    default: word_buf[7:0]   <= window;
                endcase
            end
            if (word_we) begin
                data_out <= {word_buf, window};
            end
        end
    end

endmodule
